// File: rtl/battleship_pkg.sv
// Shared definitions for the Battleship game controller: FSM state encoding,
// player identifiers and the phase-flag decode used by the display.
package battleship_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_P1_PLACE = 3'd1;
    localparam state_t ST_P2_PLACE = 3'd2;
    localparam state_t ST_P1_FIRE  = 3'd3;
    localparam state_t ST_P2_FIRE  = 3'd4;
    localparam state_t ST_SWAP     = 3'd5;
    localparam state_t ST_OVER     = 3'd6;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    // Bit order {p1place, p2place, p1fire, p2fire}; all zero outside play phases.
    function automatic logic [3:0] phase_flags(input state_t s);
        logic [3:0] f;
        f = 4'b0000;
        case (s)
            ST_P1_PLACE: f = 4'b1000;
            ST_P2_PLACE: f = 4'b0100;
            ST_P1_FIRE:  f = 4'b0010;
            ST_P2_FIRE:  f = 4'b0001;
            default:     f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/turn_phase_ctrl_if.sv
// Control/status bundle between the game front end (buttons, board logic)
// and the turn/phase controller.
interface turn_phase_ctrl_if #(
    parameter int HIT_TARGET = 17
);
    localparam int HW = $clog2(HIT_TARGET + 1);

    logic          start;
    logic          place_ok;
    logic          fire_ok;
    logic          fire_hit;
    logic          p1place;
    logic          p2place;
    logic          p1fire;
    logic          p2fire;
    logic          swap_active;
    logic          game_over;
    logic          winner;
    logic [HW-1:0] p1_hits;
    logic [HW-1:0] p2_hits;

    modport master (
        output start, place_ok, fire_ok, fire_hit,
        input  p1place, p2place, p1fire, p2fire,
        input  swap_active, game_over, winner, p1_hits, p2_hits
    );

    modport slave (
        input  start, place_ok, fire_ok, fire_hit,
        output p1place, p2place, p1fire, p2fire,
        output swap_active, game_over, winner, p1_hits, p2_hits
    );

endinterface

// File: rtl/swap_timer.sv
// Handover blank-interval timer: loads SWAP_CYCLES-1 and counts down to zero;
// done is high while the count sits at zero.
module swap_timer #(
    parameter int SWAP_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int             CW       = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    localparam logic [CW-1:0]  LOAD_VAL = CW'(SWAP_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/turn_phase_ctrl.sv
// Battleship phase sequencer: placement, alternating fire turns with a blank
// handover interval, and game-over with per-player ship and hit tracking.
module turn_phase_ctrl
    import battleship_pkg::*;
#(
    parameter int NUM_SHIPS   = 5,
    parameter int HIT_TARGET  = 17,
    parameter int SWAP_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    turn_phase_ctrl_if.slave  bus
);
    localparam int            SW        = $clog2(NUM_SHIPS + 1);
    localparam int            HW        = $clog2(HIT_TARGET + 1);
    localparam logic [SW-1:0] SHIP_MAX  = SW'(NUM_SHIPS);
    localparam logic [SW-1:0] SHIP_LAST = SW'(NUM_SHIPS - 1);
    localparam logic [HW-1:0] HIT_MAX   = HW'(HIT_TARGET);
    localparam logic [HW-1:0] HIT_LAST  = HW'(HIT_TARGET - 1);

    state_t        state_reg, state_next;
    state_t        target_reg, target_next;
    logic [3:0]    flags_reg, flags_next;
    logic          swap_active_reg, swap_active_next;
    logic          game_over_reg, game_over_next;
    logic          winner_reg, winner_next;
    logic [1:0]    place_last;
    logic [1:0]    hit_last;
    logic          clear_counts;
    logic          swap_load;
    logic          swap_done;
    logic [HW-1:0] p1_hits_w, p2_hits_w;

    assign clear_counts = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_OVER));

    // Per-player ship and hit counters; index 0 is player 1, index 1 is player 2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        localparam state_t MY_PLACE = (gi == 0) ? ST_P1_PLACE : ST_P2_PLACE;
        localparam state_t MY_FIRE  = (gi == 0) ? ST_P1_FIRE  : ST_P2_FIRE;

        logic [SW-1:0] ships_reg;
        logic [HW-1:0] hits_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ships_reg <= '0;
                hits_reg  <= '0;
            end else if (clear_counts) begin
                ships_reg <= '0;
                hits_reg  <= '0;
            end else begin
                if ((state_reg == MY_PLACE) && bus.place_ok && (ships_reg < SHIP_MAX))
                    ships_reg <= ships_reg + 1'b1;
                if ((state_reg == MY_FIRE) && bus.fire_ok && bus.fire_hit && (hits_reg < HIT_MAX))
                    hits_reg <= hits_reg + 1'b1;
            end
        end

        assign place_last[gi] = (ships_reg == SHIP_LAST);
        assign hit_last[gi]   = (hits_reg == HIT_LAST);
    end

    assign p1_hits_w = g_player[0].hits_reg;
    assign p2_hits_w = g_player[1].hits_reg;

    swap_timer #(
        .SWAP_CYCLES(SWAP_CYCLES)
    ) u_swap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (swap_load),
        .en    (state_reg == ST_SWAP),
        .done  (swap_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            target_reg <= ST_P1_PLACE;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_P1_PLACE;
            end
            ST_P1_PLACE: begin
                if (bus.place_ok && place_last[0]) begin
                    state_next  = ST_SWAP;
                    target_next = ST_P2_PLACE;
                end
            end
            ST_P2_PLACE: begin
                if (bus.place_ok && place_last[1]) begin
                    state_next  = ST_SWAP;
                    target_next = ST_P1_FIRE;
                end
            end
            ST_P1_FIRE: begin
                if (bus.fire_ok) begin
                    if (bus.fire_hit && hit_last[0]) begin
                        state_next = ST_OVER;
                    end else begin
                        state_next  = ST_SWAP;
                        target_next = ST_P2_FIRE;
                    end
                end
            end
            ST_P2_FIRE: begin
                if (bus.fire_ok) begin
                    if (bus.fire_hit && hit_last[1]) begin
                        state_next = ST_OVER;
                    end else begin
                        state_next  = ST_SWAP;
                        target_next = ST_P1_FIRE;
                    end
                end
            end
            ST_SWAP: begin
                if (swap_done) state_next = target_reg;
            end
            ST_OVER: begin
                if (bus.start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they land with the state change.
    always_comb begin
        flags_next       = phase_flags(state_next);
        swap_active_next = (state_next == ST_SWAP);
        game_over_next   = (state_next == ST_OVER);
        swap_load        = (state_next == ST_SWAP) && (state_reg != ST_SWAP);
        winner_next      = winner_reg;
        if (state_next == ST_OVER) begin
            if (state_reg == ST_P1_FIRE) winner_next = PLAYER_1;
            if (state_reg == ST_P2_FIRE) winner_next = PLAYER_2;
        end else begin
            winner_next = PLAYER_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg       <= 4'b0000;
            swap_active_reg <= 1'b0;
            game_over_reg   <= 1'b0;
            winner_reg      <= 1'b0;
        end else begin
            flags_reg       <= flags_next;
            swap_active_reg <= swap_active_next;
            game_over_reg   <= game_over_next;
            winner_reg      <= winner_next;
        end
    end

    assign bus.p1place     = flags_reg[3];
    assign bus.p2place     = flags_reg[2];
    assign bus.p1fire      = flags_reg[1];
    assign bus.p2fire      = flags_reg[0];
    assign bus.swap_active = swap_active_reg;
    assign bus.game_over   = game_over_reg;
    assign bus.winner      = winner_reg;
    assign bus.p1_hits     = p1_hits_w;
    assign bus.p2_hits     = p2_hits_w;

endmodule

// File: tb/tb_turn_phase_ctrl.sv
// Self-checking bench for turn_phase_ctrl with NUM_SHIPS=2, HIT_TARGET=3, SWAP_CYCLES=4.
module tb_turn_phase_ctrl;

    typedef struct packed {
        logic [3:0] flags;   // {p1place, p2place, p1fire, p2fire}
        logic       sw;
        logic       go;
        logic       win;
        logic [1:0] h1;
        logic [1:0] h2;
    } out_t;

    typedef struct packed {
        logic [3:0] in;      // {start, place_ok, fire_ok, fire_hit}
        out_t       exp;
    } vec_t;

    localparam logic [3:0] I_NONE  = 4'b0000;
    localparam logic [3:0] I_START = 4'b1000;
    localparam logic [3:0] I_PLACE = 4'b0100;
    localparam logic [3:0] I_FIRE  = 4'b0010;
    localparam logic [3:0] I_HIT   = 4'b0011;
    localparam logic [3:0] I_HONLY = 4'b0001;
    localparam logic [3:0] I_PF    = 4'b0110;
    localparam logic [3:0] I_ALL   = 4'b1111;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_P1P  = 4'b1000;
    localparam logic [3:0] F_P2P  = 4'b0100;
    localparam logic [3:0] F_P1F  = 4'b0010;
    localparam logic [3:0] F_P2F  = 4'b0001;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    vec_t vecs[$];
    out_t expq[$];

    turn_phase_ctrl_if #(.HIT_TARGET(3)) bus ();

    turn_phase_ctrl #(
        .NUM_SHIPS   (2),
        .HIT_TARGET  (3),
        .SWAP_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(input logic [3:0] f, input logic sw, input logic go,
                               input logic win, input logic [1:0] h1, input logic [1:0] h2);
        out_t r;
        r.flags = f; r.sw = sw; r.go = go; r.win = win; r.h1 = h1; r.h2 = h2;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.flags = {bus.p1place, bus.p2place, bus.p1fire, bus.p2fire};
        r.sw    = bus.swap_active;
        r.go    = bus.game_over;
        r.win   = bus.winner;
        r.h1    = bus.p1_hits;
        r.h2    = bus.p2_hits;
        return r;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got flags=%b sw=%b go=%b win=%b h1=%0d h2=%0d, required flags=%b sw=%b go=%b win=%b h1=%0d h2=%0d",
                     name, got.flags, got.sw, got.go, got.win, got.h1, got.h2,
                     exp.flags, exp.sw, exp.go, exp.win, exp.h1, exp.h2);
        end else begin
            $display("[TB] %s ok: flags=%b sw=%b go=%b win=%b h1=%0d h2=%0d",
                     name, got.flags, got.sw, got.go, got.win, got.h1, got.h2);
        end
    endtask

    task automatic add(input logic [3:0] in, input out_t e);
        vec_t v;
        v.in = in; v.exp = e;
        vecs.push_back(v);
    endtask

    // Trigger row entering the handover, three filler rows inside it, then the landing row.
    task automatic addswap(input logic [3:0] first, input logic [3:0] fill,
                           input logic [1:0] h1, input logic [1:0] h2, input logic [3:0] land);
        add(first, o(F_NONE, 1'b1, 1'b0, 1'b0, h1, h2));
        for (int k = 0; k < 3; k++) add(fill, o(F_NONE, 1'b1, 1'b0, 1'b0, h1, h2));
        add(I_NONE, o(land, 1'b0, 1'b0, 1'b0, h1, h2));
    endtask

    task automatic drive(input logic [3:0] in);
        {bus.start, bus.place_ok, bus.fire_ok, bus.fire_hit} = in;
    endtask

    // Entered just after a negedge; each vector is a one-cycle pulse checked on the following negedge.
    task automatic run_table(input string tag);
        out_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            expq.push_back(vecs[i].exp);
            @(posedge clk);
            #1 drive(I_NONE);
            @(negedge clk);
            e = expq.pop_front();
            check($sformatf("%s[%0d]", tag, i), sample(), e);
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        drive(I_NONE);
        repeat (3) @(negedge clk);
        check("reset", sample(), o(F_NONE, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Full game won by player 1, including ignored and simultaneous inputs.
        add(I_NONE,  o(F_NONE, 0, 0, 0, 0, 0));
        add(I_START, o(F_P1P,  0, 0, 0, 0, 0));
        add(I_PF,    o(F_P1P,  0, 0, 0, 0, 0));
        add(I_FIRE,  o(F_P1P,  0, 0, 0, 0, 0));
        addswap(I_PLACE, I_PLACE, 0, 0, F_P2P);
        add(I_PLACE, o(F_P2P,  0, 0, 0, 0, 0));
        addswap(I_PLACE, I_ALL,   0, 0, F_P1F);
        add(I_START, o(F_P1F,  0, 0, 0, 0, 0));
        add(I_HONLY, o(F_P1F,  0, 0, 0, 0, 0));
        addswap(I_HIT,  I_NONE, 1, 0, F_P2F);
        addswap(I_FIRE, I_NONE, 1, 0, F_P1F);
        addswap(I_HIT,  I_NONE, 2, 0, F_P2F);
        addswap(I_HIT,  I_NONE, 2, 1, F_P1F);
        add(I_HIT,   o(F_NONE, 0, 1, 0, 3, 1));
        add(I_HIT,   o(F_NONE, 0, 1, 0, 3, 1));
        add(I_PLACE, o(F_NONE, 0, 1, 0, 3, 1));
        add(I_NONE,  o(F_NONE, 0, 1, 0, 3, 1));
        add(I_START, o(F_NONE, 0, 0, 0, 0, 0));
        add(I_START, o(F_P1P,  0, 0, 0, 0, 0));
        add(I_PLACE, o(F_P1P,  0, 0, 0, 0, 0));
        add(I_PLACE, o(F_NONE, 1, 0, 0, 0, 0));
        add(I_NONE,  o(F_NONE, 1, 0, 0, 0, 0));
        run_table("gameA");

        // Asynchronous reset in the second handover cycle.
        #2 rst_n = 1'b0;
        #1 check("midswap_rst", sample(), o(F_NONE, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_held", sample(), o(F_NONE, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Fresh game after reset: ship count restarts at 0, player 2 wins.
        add(I_NONE,  o(F_NONE, 0, 0, 0, 0, 0));
        add(I_START, o(F_P1P,  0, 0, 0, 0, 0));
        add(I_PLACE, o(F_P1P,  0, 0, 0, 0, 0));
        addswap(I_PLACE, I_NONE, 0, 0, F_P2P);
        add(I_PLACE, o(F_P2P,  0, 0, 0, 0, 0));
        addswap(I_PLACE, I_NONE, 0, 0, F_P1F);
        addswap(I_FIRE, I_ALL,  0, 0, F_P2F);
        addswap(I_HIT,  I_NONE, 0, 1, F_P1F);
        addswap(I_FIRE, I_NONE, 0, 1, F_P2F);
        addswap(I_HIT,  I_NONE, 0, 2, F_P1F);
        addswap(I_HIT,  I_NONE, 1, 2, F_P2F);
        add(I_HIT,   o(F_NONE, 0, 1, 1, 1, 3));
        add(I_FIRE,  o(F_NONE, 0, 1, 1, 1, 3));
        add(I_START, o(F_NONE, 0, 0, 0, 0, 0));
        run_table("gameB");

        if (expq.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
